// File: rtl/clock_mode_ctrl.sv
// Clock/alarm/stopwatch mode controller: tick prescalers, key debouncers,
// mode FSM, counter strobes and the alarm ringer, all on the single CLK domain.
module clock_mode_ctrl #(
   parameter int DIV_SEC   = 50_000_000,
   parameter int DIV_CS    = 500_000,
   parameter int DB_CYCLES = 1_000_000,
   parameter int RING_SECS = 30
) (
   input  logic       CLK,
   input  logic       clr,
   input  logic       key_mode,
   input  logic       key_sel,
   input  logic       key_adj,
   input  logic       key_ss,
   input  logic       alarm_en,
   input  logic       alarm_hit,
   output logic       tick_1hz,
   output logic       tick_100hz,
   output logic [1:0] mode,
   output logic [1:0] field,
   output logic [2:0] inc_time,
   output logic [2:0] inc_alarm,
   output logic       time_run,
   output logic       sw_run,
   output logic       sw_clr,
   output logic       ring
);

   typedef enum logic [1:0] {
      M_CLOCK     = 2'b00,
      M_SET_TIME  = 2'b01,
      M_SET_ALARM = 2'b10,
      M_STOPWATCH = 2'b11
   } mode_t;

   // Key bit positions inside the packed key vectors; lower index wins on a tie.
   localparam int K_MODE = 0;
   localparam int K_SEL  = 1;
   localparam int K_ADJ  = 2;
   localparam int K_SS   = 3;

   localparam int SEC_W = $clog2(DIV_SEC + 1);
   localparam int CS_W  = $clog2(DIV_CS + 1);
   localparam int DB_W  = $clog2(DB_CYCLES + 1);
   localparam int RS_W  = $clog2(RING_SECS + 1);

   localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(DIV_SEC - 1);
   localparam logic [CS_W-1:0]  CS_LAST   = CS_W'(DIV_CS - 1);
   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [RS_W-1:0]  RING_LAST = RS_W'(RING_SECS - 1);

   function automatic logic [2:0] field_onehot(input logic [1:0] f);
      case (f)
         2'b01:   field_onehot = 3'b010;
         2'b10:   field_onehot = 3'b100;
         default: field_onehot = 3'b001;
      endcase
   endfunction

   function automatic logic [1:0] next_field(input logic [1:0] f);
      case (f)
         2'b00:   next_field = 2'b01;
         2'b01:   next_field = 2'b10;
         default: next_field = 2'b00;
      endcase
   endfunction

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         M_CLOCK:     next_mode = M_SET_TIME;
         M_SET_TIME:  next_mode = M_SET_ALARM;
         M_SET_ALARM: next_mode = M_STOPWATCH;
         default:     next_mode = M_CLOCK;
      endcase
   endfunction

   logic [SEC_W-1:0] sec_cnt_q;
   logic [CS_W-1:0]  cs_cnt_q;
   logic             tick_1hz_q, tick_100hz_q;

   logic [3:0]       keys_raw;
   logic [3:0]       sync1_q, sync2_q, level_q, level_dly_q, press_q;
   logic [DB_W-1:0]  db_cnt_q [4];

   mode_t            mode_q, mode_d;
   logic [1:0]       field_q, field_d;
   logic             sw_run_q, sw_run_d;
   logic [2:0]       inc_time_q, inc_time_d;
   logic [2:0]       inc_alarm_q, inc_alarm_d;
   logic             sw_clr_q, sw_clr_d;
   logic             ring_q, ring_d;
   logic [RS_W-1:0]  ring_cnt_q, ring_cnt_d;
   logic             hit_q;
   logic             hit_edge;

   assign keys_raw = {key_ss, key_adj, key_sel, key_mode};
   assign hit_edge = alarm_hit & ~hit_q;

   // Free-running prescalers; each tick is registered for the cycle after the count hits DIV-1.
   always_ff @(posedge CLK or posedge clr) begin
      if (clr) begin
         sec_cnt_q    <= '0;
         cs_cnt_q     <= '0;
         tick_1hz_q   <= 1'b0;
         tick_100hz_q <= 1'b0;
      end else begin
         tick_1hz_q   <= (sec_cnt_q == SEC_LAST);
         tick_100hz_q <= (cs_cnt_q == CS_LAST);
         if (sec_cnt_q == SEC_LAST) sec_cnt_q <= '0;
         else                       sec_cnt_q <= sec_cnt_q + 1'b1;
         if (cs_cnt_q == CS_LAST)   cs_cnt_q  <= '0;
         else                       cs_cnt_q  <= cs_cnt_q + 1'b1;
      end
   end

   // Per-key synchronizer, stability counter and one-cycle press on an accepted rising level.
   always_ff @(posedge CLK or posedge clr) begin
      if (clr) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         press_q     <= '0;
         for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
      end else begin
         sync1_q     <= keys_raw;
         sync2_q     <= sync1_q;
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
         for (int k = 0; k < 4; k++) begin
            if (sync2_q[k] == level_q[k]) begin
               db_cnt_q[k] <= '0;
            end else if (db_cnt_q[k] == DB_LAST) begin
               level_q[k]  <= sync2_q[k];
               db_cnt_q[k] <= '0;
            end else begin
               db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Mode FSM and control state registers.
   always_ff @(posedge CLK or posedge clr) begin
      if (clr) begin
         mode_q      <= M_CLOCK;
         field_q     <= 2'b00;
         sw_run_q    <= 1'b0;
         inc_time_q  <= 3'b000;
         inc_alarm_q <= 3'b000;
         sw_clr_q    <= 1'b0;
         ring_q      <= 1'b0;
         ring_cnt_q  <= '0;
         hit_q       <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         field_q     <= field_d;
         sw_run_q    <= sw_run_d;
         inc_time_q  <= inc_time_d;
         inc_alarm_q <= inc_alarm_d;
         sw_clr_q    <= sw_clr_d;
         ring_q      <= ring_d;
         ring_cnt_q  <= ring_cnt_d;
         hit_q       <= alarm_hit;
      end
   end

   // Next-state: a ringing alarm swallows presses; otherwise only the highest-priority press acts.
   always_comb begin
      mode_d      = mode_q;
      field_d     = field_q;
      sw_run_d    = sw_run_q;
      inc_time_d  = 3'b000;
      inc_alarm_d = 3'b000;
      sw_clr_d    = 1'b0;
      ring_d      = ring_q;
      ring_cnt_d  = ring_cnt_q;

      if (ring_q) begin
         if (|press_q) begin
            ring_d = 1'b0;
         end else if (!alarm_en) begin
            ring_d = 1'b0;
         end else if (tick_1hz_q) begin
            if (ring_cnt_q == RING_LAST) ring_d     = 1'b0;
            else                         ring_cnt_d = ring_cnt_q + 1'b1;
         end
      end else if (press_q[K_MODE]) begin
         mode_d = next_mode(mode_q);
         if (mode_d == M_SET_TIME || mode_d == M_SET_ALARM) field_d = 2'b00;
      end else if (press_q[K_SEL]) begin
         if (mode_q == M_SET_TIME || mode_q == M_SET_ALARM) field_d = next_field(field_q);
      end else if (press_q[K_ADJ]) begin
         case (mode_q)
            M_SET_TIME:  inc_time_d  = field_onehot(field_q);
            M_SET_ALARM: inc_alarm_d = field_onehot(field_q);
            M_STOPWATCH: sw_clr_d    = ~sw_run_q;
            default:     sw_clr_d    = 1'b0;
         endcase
      end else if (press_q[K_SS]) begin
         if (mode_q == M_STOPWATCH) sw_run_d = ~sw_run_q;
      end

      // A fresh hit restarts ringing even when a clear lands in the same cycle.
      if (hit_edge && alarm_en && mode_q != M_SET_TIME) begin
         ring_d     = 1'b1;
         ring_cnt_d = '0;
      end
   end

   assign tick_1hz   = tick_1hz_q;
   assign tick_100hz = tick_100hz_q;
   assign mode       = mode_q;
   assign field      = field_q;
   assign inc_time   = inc_time_q;
   assign inc_alarm  = inc_alarm_q;
   assign time_run   = (mode_q != M_SET_TIME);
   assign sw_run     = sw_run_q;
   assign sw_clr     = sw_clr_q;
   assign ring       = ring_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed table of key presses, hand-written ring and
// reset sequences, and a randomized run checked against a behavioural model.
module tb_clock_mode_ctrl;

   localparam int DIV_SEC = 10;
   localparam int DIV_CS  = 2;
   localparam int DB      = 4;
   localparam int RS      = 3;

   localparam int K_MODE = 0;
   localparam int K_SEL  = 1;
   localparam int K_ADJ  = 2;
   localparam int K_SS   = 3;

   logic       CLK = 1'b0;
   logic       clr;
   logic       key_mode, key_sel, key_adj, key_ss;
   logic       alarm_en, alarm_hit;
   logic       tick_1hz, tick_100hz;
   logic [1:0] mode, field;
   logic [2:0] inc_time, inc_alarm;
   logic       time_run, sw_run, sw_clr, ring;

   clock_mode_ctrl #(
      .DIV_SEC   (DIV_SEC),
      .DIV_CS    (DIV_CS),
      .DB_CYCLES (DB),
      .RING_SECS (RS)
   ) dut (
      .CLK        (CLK),
      .clr        (clr),
      .key_mode   (key_mode),
      .key_sel    (key_sel),
      .key_adj    (key_adj),
      .key_ss     (key_ss),
      .alarm_en   (alarm_en),
      .alarm_hit  (alarm_hit),
      .tick_1hz   (tick_1hz),
      .tick_100hz (tick_100hz),
      .mode       (mode),
      .field      (field),
      .inc_time   (inc_time),
      .inc_alarm  (inc_alarm),
      .time_run   (time_run),
      .sw_run     (sw_run),
      .sw_clr     (sw_clr),
      .ring       (ring)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int         m_n;
   logic [7:0] m_hist [4];
   logic [3:0] m_lvl1, m_lvl2, m_press;
   logic       m_tick1, m_tick100;
   logic [1:0] m_mode, m_field;
   logic [2:0] m_inc_t, m_inc_a;
   logic       m_sw_run, m_sw_clr, m_ring, m_hit_prev;
   int         m_ring_ticks;

   task automatic model_reset();
      m_n = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
      m_lvl1 = 4'h0; m_lvl2 = 4'h0; m_press = 4'h0;
      m_tick1 = 1'b0; m_tick100 = 1'b0;
      m_mode = 2'b00; m_field = 2'b00;
      m_inc_t = 3'b000; m_inc_a = 3'b000;
      m_sw_run = 1'b0; m_sw_clr = 1'b0; m_ring = 1'b0; m_hit_prev = 1'b0;
      m_ring_ticks = 0;
   endtask

   // One clock edge: the inputs are those present just before the edge.
   task automatic model_edge(input logic [3:0] kin, input logic en, input logic hit);
      logic [1:0] old_mode;
      logic [7:0] w, msk;
      m_n++;
      old_mode = m_mode;
      m_inc_t  = 3'b000;
      m_inc_a  = 3'b000;
      m_sw_clr = 1'b0;
      if (m_press != 4'h0) begin
         if (m_ring) begin
            m_ring = 1'b0;
         end else if (m_press[K_MODE]) begin
            m_mode = m_mode + 2'd1;
            if (m_mode == 2'd1 || m_mode == 2'd2) m_field = 2'd0;
         end else if (m_press[K_SEL]) begin
            if (old_mode == 2'd1 || old_mode == 2'd2)
               m_field = (m_field == 2'd2) ? 2'd0 : m_field + 2'd1;
         end else if (m_press[K_ADJ]) begin
            if (old_mode == 2'd1) m_inc_t = 3'b001 << m_field;
            if (old_mode == 2'd2) m_inc_a = 3'b001 << m_field;
            if (old_mode == 2'd3 && !m_sw_run) m_sw_clr = 1'b1;
         end else begin
            if (old_mode == 2'd3) m_sw_run = !m_sw_run;
         end
      end else if (m_ring) begin
         if (!en) begin
            m_ring = 1'b0;
         end else if (m_tick1) begin
            m_ring_ticks++;
            if (m_ring_ticks == RS) m_ring = 1'b0;
         end
      end
      if (hit && !m_hit_prev && en && old_mode != 2'd1) begin
         m_ring = 1'b1;
         m_ring_ticks = 0;
      end
      m_hit_prev = hit;
      m_tick1   = (m_n % DIV_SEC) == 0;
      m_tick100 = (m_n % DIV_CS) == 0;
      // A key level is accepted once the last DB synchronized samples (raw delayed by two) all disagree.
      msk = 8'((1 << DB) - 1);
      for (int i = 0; i < 4; i++) begin
         m_press[i] = m_lvl1[i] & ~m_lvl2[i];
         m_lvl2[i]  = m_lvl1[i];
         m_hist[i]  = {m_hist[i][6:0], kin[i]};
         w = (m_hist[i] >> 2) & msk;
         if (!m_lvl1[i] && w == msk)      m_lvl1[i] = 1'b1;
         else if (m_lvl1[i] && w == 8'h0) m_lvl1[i] = 1'b0;
      end
   endtask

   logic [2:0] acc_t, acc_a;
   int         acc_pulse, acc_clr;

   task automatic cyc();
      logic [3:0] kc;
      logic       ec, hc;
      kc = {key_ss, key_adj, key_sel, key_mode};
      ec = alarm_en;
      hc = alarm_hit;
      @(posedge CLK);
      #1;
      model_edge(kc, ec, hc);
      check($sformatf("model@%0d", m_n),
            32'({tick_1hz, tick_100hz, mode, field, inc_time, inc_alarm, time_run, sw_run, sw_clr, ring}),
            32'({m_tick1, m_tick100, m_mode, m_field, m_inc_t, m_inc_a, (m_mode != 2'd1), m_sw_run, m_sw_clr, m_ring}));
      acc_t |= inc_time;
      acc_a |= inc_alarm;
      if (inc_time != 3'b000 || inc_alarm != 3'b000) acc_pulse++;
      if (sw_clr) acc_clr++;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         K_MODE:  key_mode = v;
         K_SEL:   key_sel  = v;
         K_ADJ:   key_adj  = v;
         default: key_ss   = v;
      endcase
   endtask

   task automatic press(input int k);
      set_key(k, 1'b1);
      repeat (DB + 4) cyc();
      set_key(k, 1'b0);
      repeat (DB + 4) cyc();
   endtask

   typedef struct {
      int         key;
      logic [1:0] mode;
      logic [1:0] field;
      logic [2:0] inc_t;
      logic [2:0] inc_a;
      logic       sw_clr;
      logic       sw_run;
   } vec_t;

   vec_t tbl [20];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, tcount;
      logic last, done;

      // Starts in SET_TIME, field sec.
      tbl[0]  = '{K_ADJ,  2'b01, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0};
      tbl[1]  = '{K_SEL,  2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[2]  = '{K_ADJ,  2'b01, 2'b01, 3'b010, 3'b000, 1'b0, 1'b0};
      tbl[3]  = '{K_SEL,  2'b01, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[4]  = '{K_SEL,  2'b01, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[5]  = '{K_ADJ,  2'b01, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0};
      tbl[6]  = '{K_MODE, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[7]  = '{K_SEL,  2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[8]  = '{K_SEL,  2'b10, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[9]  = '{K_ADJ,  2'b10, 2'b10, 3'b000, 3'b100, 1'b0, 1'b0};
      tbl[10] = '{K_MODE, 2'b11, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[11] = '{K_SS,   2'b11, 2'b10, 3'b000, 3'b000, 1'b0, 1'b1};
      tbl[12] = '{K_ADJ,  2'b11, 2'b10, 3'b000, 3'b000, 1'b0, 1'b1};
      tbl[13] = '{K_SS,   2'b11, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[14] = '{K_ADJ,  2'b11, 2'b10, 3'b000, 3'b000, 1'b1, 1'b0};
      tbl[15] = '{K_SS,   2'b11, 2'b10, 3'b000, 3'b000, 1'b0, 1'b1};
      tbl[16] = '{K_MODE, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b1};
      tbl[17] = '{K_SEL,  2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b1};
      tbl[18] = '{K_ADJ,  2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b1};
      tbl[19] = '{K_SS,   2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b1};

      clr = 1'b1;
      key_mode = 1'b0; key_sel = 1'b0; key_adj = 1'b0; key_ss = 1'b0;
      alarm_en = 1'b0; alarm_hit = 1'b0;
      acc_t = 3'b000; acc_a = 3'b000; acc_pulse = 0; acc_clr = 0;
      model_reset();

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_outputs",
            32'({tick_1hz, tick_100hz, mode, field, inc_time, inc_alarm, time_run, sw_run, sw_clr, ring}),
            32'(16'b0000_0000_0000_1000));
      clr = 1'b0;
      model_reset();

      // Tick cadence after reset release.
      for (int e = 1; e <= 35; e++) begin
         cyc();
         check($sformatf("tick1hz_e%0d", e), 32'(tick_1hz), 32'((e % DIV_SEC) == 0));
         check($sformatf("tick100hz_e%0d", e), 32'(tick_100hz), 32'((e % DIV_CS) == 0));
      end

      // Three-cycle glitch must not register.
      key_mode = 1'b1;
      repeat (3) cyc();
      key_mode = 1'b0;
      repeat (12) cyc();
      check("glitch_mode", 32'(mode), 32'(0));

      // Steady hold: press after edge DB+3, mode changes on edge DB+4, exactly once.
      key_mode = 1'b1;
      first = 0;
      for (int e = 1; e <= 20; e++) begin
         cyc();
         if (first == 0 && mode == 2'b01) first = e;
      end
      key_mode = 1'b0;
      repeat (DB + 4) cyc();
      check("hold_latency", 32'(first), 32'(DB + 4));
      check("hold_mode", 32'(mode), 32'(1));
      check("hold_field", 32'(field), 32'(0));

      for (int i = 0; i < 20; i++) begin
         acc_t = 3'b000; acc_a = 3'b000; acc_pulse = 0; acc_clr = 0;
         press(tbl[i].key);
         check($sformatf("vec%0d_mode", i), 32'(mode), 32'(tbl[i].mode));
         check($sformatf("vec%0d_field", i), 32'(field), 32'(tbl[i].field));
         check($sformatf("vec%0d_inc_time", i), 32'(acc_t), 32'(tbl[i].inc_t));
         check($sformatf("vec%0d_inc_alarm", i), 32'(acc_a), 32'(tbl[i].inc_a));
         check($sformatf("vec%0d_inc_cycles", i), 32'(acc_pulse),
               32'((tbl[i].inc_t != 3'b000 || tbl[i].inc_a != 3'b000) ? 1 : 0));
         check($sformatf("vec%0d_sw_clr", i), 32'(acc_clr), 32'(tbl[i].sw_clr));
         check($sformatf("vec%0d_sw_run", i), 32'(sw_run), 32'(tbl[i].sw_run));
         check($sformatf("vec%0d_time_run", i), 32'(time_run), 32'(tbl[i].mode != 2'b01));
      end

      // Ring self-clears on the RS-th tick after being set.
      alarm_en = 1'b1;
      cyc();
      alarm_hit = 1'b1;
      cyc();
      check("ring_set", 32'(ring), 32'(1));
      tcount = tick_1hz ? 1 : 0;
      last   = tick_1hz;
      done   = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         cyc();
         if (!ring) done = 1'b1;
         else begin
            if (tick_1hz) tcount++;
            last = tick_1hz;
         end
      end
      check("ring_clear_seen", 32'(done), 32'(1));
      check("ring_tick_count", 32'(tcount), 32'(RS));
      check("ring_last_tick", 32'(last), 32'(1));

      // A press while ringing only silences it.
      alarm_hit = 1'b0;
      cyc();
      alarm_hit = 1'b1;
      cyc();
      check("ring_set2", 32'(ring), 32'(1));
      press(K_SS);
      check("ring_press_ring", 32'(ring), 32'(0));
      check("ring_press_mode", 32'(mode), 32'(0));
      check("ring_press_swrun", 32'(sw_run), 32'(1));

      // No ringing while setting the time.
      press(K_MODE);
      alarm_hit = 1'b0;
      cyc();
      alarm_hit = 1'b1;
      repeat (3) cyc();
      check("ring_in_settime", 32'(ring), 32'(0));

      // Async clear mid-cycle from STOPWATCH, running, ringing.
      press(K_MODE);
      press(K_MODE);
      alarm_hit = 1'b0;
      cyc();
      alarm_hit = 1'b1;
      cyc();
      check("pre_clr_mode", 32'(mode), 32'(3));
      check("pre_clr_swrun", 32'(sw_run), 32'(1));
      check("pre_clr_ring", 32'(ring), 32'(1));
      #3 clr = 1'b1;
      #1;
      check("aclr_mode", 32'(mode), 32'(0));
      check("aclr_field", 32'(field), 32'(0));
      check("aclr_swrun", 32'(sw_run), 32'(0));
      check("aclr_ring", 32'(ring), 32'(0));
      check("aclr_timerun", 32'(time_run), 32'(1));
      check("aclr_strobes", 32'({inc_time, inc_alarm, sw_clr, tick_1hz, tick_100hz}), 32'(0));
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      clr = 1'b0;
      model_reset();

      // Randomized keys and alarm inputs against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 11) == 0) key_mode = ~key_mode;
         if ($urandom_range(0, 11) == 0) key_sel  = ~key_sel;
         if ($urandom_range(0, 11) == 0) key_adj  = ~key_adj;
         if ($urandom_range(0, 11) == 0) key_ss   = ~key_ss;
         if ($urandom_range(0, 59) == 0) alarm_en  = ~alarm_en;
         if ($urandom_range(0, 19) == 0) alarm_hit = ~alarm_hit;
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
